// File: rtl/svm_sched_pkg.sv
// Shared scheduler definitions: conflict-mode encodings, batch FSM states and
// the saturating counter increment used by the statistics counters.
package svm_sched_pkg;

  localparam int CONFLICT_MODE_REJECT = 0;
  localparam int CONFLICT_MODE_CARRY  = 1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } batch_state_e;

  // Counters up to 64 bits wide share this helper; the caller passes its width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_value;
    max_value = {64{1'b1}} >> (64 - width);
    return (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/svm_conflict_check.sv
// Combinational RAW/WAW/WAR hazard check of one transaction's dependency
// bitmaps against the accumulated read/write sets of a batch.
module svm_conflict_check #(
  parameter int DEP_WIDTH = 1024
) (
  input  logic [DEP_WIDTH-1:0] rd,
  input  logic [DEP_WIDTH-1:0] wr,
  input  logic [DEP_WIDTH-1:0] batch_rd,
  input  logic [DEP_WIDTH-1:0] batch_wr,
  output logic                 raw,
  output logic                 waw,
  output logic                 war
);

  assign raw = |(rd & batch_wr);
  assign waw = |(wr & batch_wr);
  assign war = |(wr & batch_rd);

endmodule

// File: rtl/svm_batch_builder.sv
// Groups hazard-free transactions into batches of up to MAX_BATCH_SIZE and
// replays each batch on a master stream, tlast marking the final entry.
module svm_batch_builder
  import svm_sched_pkg::*;
#(
  parameter int ID_WIDTH             = 64,
  parameter int DEP_WIDTH            = 1024,
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 100,
  parameter int CONFLICT_MODE        = 0,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [ID_WIDTH-1:0]                     s_axis_tdata_owner_programID,
  input  logic [DEP_WIDTH-1:0]                    s_axis_tdata_read_dependencies,
  input  logic [DEP_WIDTH-1:0]                    s_axis_tdata_write_dependencies,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [ID_WIDTH-1:0]                     m_axis_tdata_owner_programID,
  output logic [DEP_WIDTH-1:0]                    m_axis_tdata_read_dependencies,
  output logic [DEP_WIDTH-1:0]                    m_axis_tdata_write_dependencies,
  output logic                                    m_axis_tlast,
  output logic [CNT_WIDTH-1:0]                    raw_conflicts,
  output logic [CNT_WIDTH-1:0]                    waw_conflicts,
  output logic [CNT_WIDTH-1:0]                    war_conflicts,
  output logic [CNT_WIDTH-1:0]                    rejected_count,
  output logic [CNT_WIDTH-1:0]                    batches_emitted,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]     batch_occupancy
);

  localparam int OCC_W   = $clog2(MAX_BATCH_SIZE + 1);
  localparam int IDX_W   = $clog2(MAX_BATCH_SIZE);
  localparam int TMR_W   = $clog2(BATCH_TIMEOUT_CYCLES + 1);
  localparam int ENTRY_W = ID_WIDTH + 2 * DEP_WIDTH;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_BATCH_SIZE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BATCH_TIMEOUT_CYCLES - 1);
  localparam bit CARRY_ON_CONFLICT = (CONFLICT_MODE == CONFLICT_MODE_CARRY);

  batch_state_e         state_reg, state_next;
  logic [ENTRY_W-1:0]   buffer_mem [MAX_BATCH_SIZE];
  logic [OCC_W-1:0]     occ_reg;
  logic [IDX_W-1:0]     rd_idx_reg;
  logic [TMR_W-1:0]     timer_reg;
  logic [DEP_WIDTH-1:0] batch_rd_reg, batch_wr_reg;
  logic                 carry_valid_reg;
  logic [ENTRY_W-1:0]   carry_reg;
  logic [CNT_WIDTH-1:0] raw_cnt_reg, waw_cnt_reg, war_cnt_reg, rej_cnt_reg, batch_cnt_reg;

  logic               raw_hit, waw_hit, war_hit, conflict;
  logic               fill_ready, accept, take, out_fire, last_entry, timeout_hit;
  logic [OCC_W-1:0]   occ_plus;
  logic [ENTRY_W-1:0] in_entry, out_entry;

  svm_conflict_check #(
    .DEP_WIDTH(DEP_WIDTH)
  ) u_check (
    .rd       (s_axis_tdata_read_dependencies),
    .wr       (s_axis_tdata_write_dependencies),
    .batch_rd (batch_rd_reg),
    .batch_wr (batch_wr_reg),
    .raw      (raw_hit),
    .waw      (waw_hit),
    .war      (war_hit)
  );

  assign in_entry    = {s_axis_tdata_owner_programID, s_axis_tdata_read_dependencies,
                        s_axis_tdata_write_dependencies};
  assign conflict    = raw_hit | waw_hit | war_hit;
  assign fill_ready  = (state_reg == FILL) & ~carry_valid_reg & ~rst;
  assign accept      = s_axis_tvalid & fill_ready;
  assign take        = accept & ~conflict;
  assign occ_plus    = occ_reg + OCC_W'(1);
  assign timeout_hit = (occ_reg != '0) && (timer_reg == TMR_LAST);
  assign out_fire    = (state_reg == DRAIN) & m_axis_tready;
  assign last_entry  = (OCC_W'(rd_idx_reg) == occ_reg - OCC_W'(1));
  assign out_entry   = buffer_mem[rd_idx_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: begin
        if ((take && occ_plus == OCC_FULL) || timeout_hit ||
            (accept && conflict && CARRY_ON_CONFLICT))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (out_fire && last_entry)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FILL;
      occ_reg         <= '0;
      rd_idx_reg      <= '0;
      timer_reg       <= '0;
      batch_rd_reg    <= '0;
      batch_wr_reg    <= '0;
      carry_valid_reg <= 1'b0;
      raw_cnt_reg     <= '0;
      waw_cnt_reg     <= '0;
      war_cnt_reg     <= '0;
      rej_cnt_reg     <= '0;
      batch_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FILL) begin
        // Timer starts at zero on the first entry and runs while the batch is non-empty.
        if (take && occ_reg == '0)
          timer_reg <= '0;
        else if (occ_reg != '0)
          timer_reg <= timer_reg + TMR_W'(1);
        if (take) begin
          batch_rd_reg <= batch_rd_reg | s_axis_tdata_read_dependencies;
          batch_wr_reg <= batch_wr_reg | s_axis_tdata_write_dependencies;
          occ_reg      <= occ_plus;
        end
        if (accept && conflict) begin
          if (raw_hit) raw_cnt_reg <= CNT_WIDTH'(sat_inc(64'(raw_cnt_reg), CNT_WIDTH));
          if (waw_hit) waw_cnt_reg <= CNT_WIDTH'(sat_inc(64'(waw_cnt_reg), CNT_WIDTH));
          if (war_hit) war_cnt_reg <= CNT_WIDTH'(sat_inc(64'(war_cnt_reg), CNT_WIDTH));
          if (CARRY_ON_CONFLICT) begin
            carry_reg       <= in_entry;
            carry_valid_reg <= 1'b1;
          end else begin
            rej_cnt_reg <= CNT_WIDTH'(sat_inc(64'(rej_cnt_reg), CNT_WIDTH));
          end
        end
      end else if (out_fire) begin
        if (last_entry) begin
          batch_cnt_reg <= CNT_WIDTH'(sat_inc(64'(batch_cnt_reg), CNT_WIDTH));
          rd_idx_reg    <= '0;
          timer_reg     <= '0;
          // A carried transaction seeds the next batch as entry 0.
          if (carry_valid_reg) begin
            batch_rd_reg    <= carry_reg[2*DEP_WIDTH-1 -: DEP_WIDTH];
            batch_wr_reg    <= carry_reg[DEP_WIDTH-1:0];
            occ_reg         <= OCC_W'(1);
            carry_valid_reg <= 1'b0;
          end else begin
            batch_rd_reg <= '0;
            batch_wr_reg <= '0;
            occ_reg      <= '0;
          end
        end else begin
          rd_idx_reg <= rd_idx_reg + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take)
      buffer_mem[occ_reg[IDX_W-1:0]] <= in_entry;
    else if (out_fire && last_entry && carry_valid_reg)
      buffer_mem[0] <= carry_reg;
  end

  assign s_axis_tready   = fill_ready;
  assign m_axis_tvalid   = (state_reg == DRAIN);
  assign m_axis_tlast    = m_axis_tvalid & last_entry;
  assign m_axis_tdata_owner_programID    = m_axis_tvalid ? out_entry[ENTRY_W-1 -: ID_WIDTH] : '0;
  assign m_axis_tdata_read_dependencies  = m_axis_tvalid ? out_entry[2*DEP_WIDTH-1 -: DEP_WIDTH] : '0;
  assign m_axis_tdata_write_dependencies = m_axis_tvalid ? out_entry[DEP_WIDTH-1:0] : '0;
  assign raw_conflicts   = raw_cnt_reg;
  assign waw_conflicts   = waw_cnt_reg;
  assign war_conflicts   = war_cnt_reg;
  assign rejected_count  = rej_cnt_reg;
  assign batches_emitted = batch_cnt_reg;
  assign batch_occupancy = occ_reg;

endmodule

// File: tb/tb_svm_batch_builder.sv
// Directed bench for svm_batch_builder: instance 0 rejects conflicts, instance 1
// carries them; a vector table plus hand-written timeout/back-pressure/reset runs.
module tb_svm_batch_builder;
  localparam int IDW = 64;
  localparam int DW  = 1024;
  localparam int MB  = 4;
  localparam int TO  = 20;
  localparam int CW  = 32;
  localparam int OW  = $clog2(MB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [IDW-1:0] s_id;
  logic [DW-1:0]  s_rd, s_wr;
  logic           s_tvalid [2];
  logic           s_tready [2];
  logic           m_tvalid [2];
  logic           m_tready [2];
  logic           m_tlast  [2];
  logic [IDW-1:0] m_id [2];
  logic [DW-1:0]  m_rd [2];
  logic [DW-1:0]  m_wr [2];
  logic [CW-1:0]  raw_c [2];
  logic [CW-1:0]  waw_c [2];
  logic [CW-1:0]  war_c [2];
  logic [CW-1:0]  rej_c [2];
  logic [CW-1:0]  bat_c [2];
  logic [OW-1:0]  occ [2];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    svm_batch_builder #(
      .ID_WIDTH(IDW), .DEP_WIDTH(DW), .MAX_BATCH_SIZE(MB),
      .BATCH_TIMEOUT_CYCLES(TO), .CONFLICT_MODE(gi), .CNT_WIDTH(CW)
    ) dut (
      .clk                             (clk),
      .rst                             (rst),
      .s_axis_tvalid                   (s_tvalid[gi]),
      .s_axis_tready                   (s_tready[gi]),
      .s_axis_tdata_owner_programID    (s_id),
      .s_axis_tdata_read_dependencies  (s_rd),
      .s_axis_tdata_write_dependencies (s_wr),
      .m_axis_tvalid                   (m_tvalid[gi]),
      .m_axis_tready                   (m_tready[gi]),
      .m_axis_tdata_owner_programID    (m_id[gi]),
      .m_axis_tdata_read_dependencies  (m_rd[gi]),
      .m_axis_tdata_write_dependencies (m_wr[gi]),
      .m_axis_tlast                    (m_tlast[gi]),
      .raw_conflicts                   (raw_c[gi]),
      .waw_conflicts                   (waw_c[gi]),
      .war_conflicts                   (war_c[gi]),
      .rejected_count                  (rej_c[gi]),
      .batches_emitted                 (bat_c[gi]),
      .batch_occupancy                 (occ[gi])
    );
  end

  typedef enum {OP_SEND, OP_RECV} op_e;
  typedef struct {
    op_e         op;
    int          sel;
    logic [63:0] id;
    logic [63:0] rd;
    logic [63:0] wr;
    logic        last;
    int          occ, raw, waw, war, rej, bat;
    logic        tready;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(op_e op, int sel, logic [63:0] id, logic [63:0] rd,
                              logic [63:0] wr, logic last, int o, int r, int ww,
                              int wa, int rj, int b, logic tr);
    vec_t v;
    v.op = op; v.sel = sel; v.id = id; v.rd = rd; v.wr = wr; v.last = last;
    v.occ = o; v.raw = r; v.waw = ww; v.war = wa; v.rej = rj; v.bat = b; v.tready = tr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ..%0h, expected ..%0h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int sel, input logic [63:0] id, input logic [63:0] rd, input logic [63:0] wr);
    int w;
    w = 0;
    s_id = id; s_rd = DW'(rd); s_wr = DW'(wr);
    s_tvalid[sel] = 1'b1;
    while (!s_tready[sel] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("send_ready id=%0h", id), 64'(s_tready[sel]), 64'd1);
    @(negedge clk);
    s_tvalid[sel] = 1'b0;
  endtask

  // Waits for valid with tready low, then handshakes exactly one entry.
  task automatic recv(input int sel, input logic [63:0] id, input logic [63:0] rd,
                      input logic [63:0] wr, input logic last, input int budget);
    int w;
    w = 0;
    while (!m_tvalid[sel] && w < budget) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("recv_valid id=%0h", id), 64'(m_tvalid[sel]), 64'd1);
    if (m_tvalid[sel]) begin
      check("recv_id", m_id[sel], id);
      check_wide("recv_rd", m_rd[sel], DW'(rd));
      check_wide("recv_wr", m_wr[sel], DW'(wr));
      check($sformatf("recv_last id=%0h", id), 64'(m_tlast[sel]), 64'(last));
      m_tready[sel] = 1'b1;
      @(negedge clk);
      m_tready[sel] = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Rows: op sel id rd wr last | expected occ raw waw war rej bat tready after the op.
    // 0x11 also reads 0x400 so that 0x12 (rd/wr 0x400) raises RAW, WAW and WAR.
    tbl[0]  = mk(OP_SEND, 0, 64'h1,  64'h1,    64'h2,    1'b0, 1, 0, 0, 0, 0, 0, 1'b1);
    tbl[1]  = mk(OP_SEND, 0, 64'h2,  64'h4,    64'h8,    1'b0, 2, 0, 0, 0, 0, 0, 1'b1);
    tbl[2]  = mk(OP_SEND, 0, 64'h3,  64'h10,   64'h20,   1'b0, 3, 0, 0, 0, 0, 0, 1'b1);
    tbl[3]  = mk(OP_SEND, 0, 64'h4,  64'h40,   64'h80,   1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    tbl[4]  = mk(OP_RECV, 0, 64'h1,  64'h1,    64'h2,    1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    tbl[5]  = mk(OP_RECV, 0, 64'h2,  64'h4,    64'h8,    1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    tbl[6]  = mk(OP_RECV, 0, 64'h3,  64'h10,   64'h20,   1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    tbl[7]  = mk(OP_RECV, 0, 64'h4,  64'h40,   64'h80,   1'b1, 0, 0, 0, 0, 0, 1, 1'b1);
    tbl[8]  = mk(OP_SEND, 0, 64'h11, 64'h400,  64'h400,  1'b0, 1, 0, 0, 0, 0, 1, 1'b1);
    tbl[9]  = mk(OP_SEND, 0, 64'h12, 64'h400,  64'h400,  1'b0, 1, 1, 1, 1, 1, 1, 1'b1);
    tbl[10] = mk(OP_RECV, 0, 64'h11, 64'h400,  64'h400,  1'b1, 0, 1, 1, 1, 1, 2, 1'b1);
    tbl[11] = mk(OP_SEND, 1, 64'h16, 64'h2000, 64'h4000, 1'b0, 1, 0, 0, 0, 0, 0, 1'b1);
    tbl[12] = mk(OP_SEND, 1, 64'h17, 64'h4000, 64'h2000, 1'b0, 1, 1, 0, 1, 0, 0, 1'b0);
    tbl[13] = mk(OP_RECV, 1, 64'h16, 64'h2000, 64'h4000, 1'b1, 1, 1, 0, 1, 0, 1, 1'b1);
    tbl[14] = mk(OP_RECV, 1, 64'h17, 64'h4000, 64'h2000, 1'b1, 0, 1, 0, 1, 0, 2, 1'b1);

    rst = 1'b1;
    s_id = '0; s_rd = '0; s_wr = '0;
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = 1'b0;
      m_tready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tready%0d", d), 64'(s_tready[d]), 64'd0);
      check($sformatf("rst_tvalid%0d", d), 64'(m_tvalid[d]), 64'd0);
      check($sformatf("rst_occ%0d", d), 64'(occ[d]), 64'd0);
      check($sformatf("rst_bat%0d", d), 64'(bat_c[d]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 64'(s_tready[0]), 64'd1);

    for (int i = 0; i < 15; i++) begin
      int s;
      s = tbl[i].sel;
      if (tbl[i].op == OP_SEND) begin
        send(s, tbl[i].id, tbl[i].rd, tbl[i].wr);
        // A full batch must be visible on the master port one cycle after closing.
        if (i == 3) check("full_close_latency", 64'(m_tvalid[0]), 64'd1);
      end else begin
        recv(s, tbl[i].id, tbl[i].rd, tbl[i].wr, tbl[i].last, 100);
      end
      check($sformatf("r%0d_occ", i), 64'(occ[s]), 64'(tbl[i].occ));
      check($sformatf("r%0d_raw", i), 64'(raw_c[s]), 64'(tbl[i].raw));
      check($sformatf("r%0d_waw", i), 64'(waw_c[s]), 64'(tbl[i].waw));
      check($sformatf("r%0d_war", i), 64'(war_c[s]), 64'(tbl[i].war));
      check($sformatf("r%0d_rej", i), 64'(rej_c[s]), 64'(tbl[i].rej));
      check($sformatf("r%0d_bat", i), 64'(bat_c[s]), 64'(tbl[i].bat));
      check($sformatf("r%0d_tready", i), 64'(s_tready[s]), 64'(tbl[i].tready));
    end

    // Timeout: timer is 0 in the cycle after acceptance and closes at TO-1, so
    // valid shows TO edges after the accepting edge.
    send(0, 64'h5, 64'h0, 64'h0);
    check("tmo_occ_before", 64'(occ[0]), 64'd1);
    n = 0;
    while (!m_tvalid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 64'(n), 64'(TO));
    recv(0, 64'h5, 64'h0, 64'h0, 1'b1, 5);
    check("tmo_occ_after", 64'(occ[0]), 64'd0);
    check("tmo_bat", 64'(bat_c[0]), 64'd3);

    // Back-pressure: hold the second entry for five cycles.
    for (int k = 0; k < 4; k++) send(0, 64'h21 + 64'(k), 64'h0, 64'h0);
    recv(0, 64'h21, 64'h0, 64'h0, 1'b0, 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 64'(m_tvalid[0]), 64'd1);
      check($sformatf("bp_id%0d", k), m_id[0], 64'h22);
      check($sformatf("bp_last%0d", k), 64'(m_tlast[0]), 64'd0);
      @(negedge clk);
    end
    recv(0, 64'h22, 64'h0, 64'h0, 1'b0, 5);
    recv(0, 64'h23, 64'h0, 64'h0, 1'b0, 5);
    recv(0, 64'h24, 64'h0, 64'h0, 1'b1, 5);
    check("bp_bat", 64'(bat_c[0]), 64'd4);

    // Reset after the second of four outputs.
    for (int k = 0; k < 4; k++) send(0, 64'h31 + 64'(k), 64'h0, 64'h0);
    recv(0, 64'h31, 64'h0, 64'h0, 1'b0, 5);
    recv(0, 64'h32, 64'h0, 64'h0, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("mid_rst_tready", 64'(s_tready[0]), 64'd0);
    check("mid_rst_raw", 64'(raw_c[0]), 64'd0);
    check("mid_rst_rej", 64'(rej_c[0]), 64'd0);
    check("mid_rst_bat", 64'(bat_c[0]), 64'd0);
    check("mid_rst_occ", 64'(occ[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_tready", 64'(s_tready[0]), 64'd1);
    send(0, 64'h41, 64'h8, 64'h10);
    check("fresh_occ", 64'(occ[0]), 64'd1);
    recv(0, 64'h41, 64'h8, 64'h10, 1'b1, 100);
    check("fresh_bat", 64'(bat_c[0]), 64'd1);
    check("fresh_occ_after", 64'(occ[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
